mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the processor's data bus, alongside data memory. Consumes MemWrite/DataAddress/WriteData from the CPU top level. Buffers bytes in a small FIFO and serialises them 8N1 on a single tx line. Supplies combinational read data and an address-hit flag so the top level can mux peripheral reads against data memory.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 59 +++++
 rtl/mmio_uart_tx.sv | 207 ++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter.
// Holds register offsets, STATUS bit positions and the serialiser state type.
package uart_pkg;

    localparam logic [31:0] TXDATA_OFS  = 32'h0;
    localparam logic [31:0] STATUS_OFS  = 32'h4;
    localparam logic [31:0] DIVISOR_OFS = 32'h8;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    localparam logic [15:0] MIN_DIVISOR = 16'd2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a read-ahead head (dout always shows the oldest entry).
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     Reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS/DIVISOR window, byte FIFO, 8N1 serialiser.
// Define UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit (tx=0) for one bit period
// DATA   | eight data bits, LSB first
// PARITY | even parity of the data byte (UART_PARITY_EN builds only)
// STOP   | stop bit (tx=1); chains straight into START if more bytes wait
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [15:0] CLKS_PER_BIT = 16'd16
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAddress,
    input  logic [31:0] WriteData,
    output logic [31:0] rd_data,
    output logic        sel,
    output logic        tx,
    output logic        busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   ofs;
    logic          hit_tx;
    logic          hit_st;
    logic          hit_dv;
    logic          wr_tx;
    logic          wr_st;
    logic          wr_dv;
    logic [15:0]   divisor;
    logic          overflow;
    logic [3:0]    status;
    logic          unused_wdata;

    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          pop;

    uart_state_t   state;
    logic [15:0]   cyc;
    logic [15:0]   div_lat;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
`ifdef UART_PARITY_EN
    logic          parity;
`endif

    assign ofs    = DataAddress - BASE_ADDR;
    assign hit_tx = (ofs == TXDATA_OFS);
    assign hit_st = (ofs == STATUS_OFS);
    assign hit_dv = (ofs == DIVISOR_OFS);
    assign sel    = hit_tx || hit_st || hit_dv;

    assign wr_tx  = MemWrite && hit_tx;
    assign wr_st  = MemWrite && hit_st;
    assign wr_dv  = MemWrite && hit_dv;

    assign unused_wdata = ^WriteData[31:16];

    always_comb begin
        status          = '0;
        status[ST_FULL]  = (fifo_count == CW'(FIFO_DEPTH));
        status[ST_EMPTY] = fifo_empty;
        status[ST_BUSY]  = busy;
        status[ST_OVF]   = overflow;
    end

    always_comb begin
        rd_data = '0;
        if (hit_st) begin
            rd_data = {28'b0, status};
        end else if (hit_dv) begin
            rd_data = {16'b0, divisor};
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            divisor <= CLKS_PER_BIT;
        end else if (wr_dv) begin
            divisor <= (WriteData[15:0] < MIN_DIVISOR) ? MIN_DIVISOR : WriteData[15:0];
        end
    end

    // A same-cycle pop makes room, so a push into a full FIFO is not an overflow then.
    always_ff @(posedge clk) begin
        if (Reset) begin
            overflow <= 1'b0;
        end else if (wr_st) begin
            overflow <= 1'b0;
        end else if (wr_tx && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .Reset (Reset),
        .push  (wr_tx),
        .pop   (pop),
        .din   (WriteData[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && (cyc == 16'd0)));

    // cyc counts down to 0 within each bit period; every frame start reloads the divisor.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            cyc     <= '0;
            div_lat <= CLKS_PER_BIT;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef UART_PARITY_EN
            parity  <= 1'b0;
`endif
        end else if (pop) begin
            state   <= START;
            tx      <= 1'b0;
            busy    <= 1'b1;
            shreg   <= fifo_dout;
            div_lat <= divisor;
            cyc     <= divisor - 16'd1;
            bit_idx <= '0;
`ifdef UART_PARITY_EN
            parity  <= ^fifo_dout;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                end
                START: begin
                    if (cyc == 16'd0) begin
                        state   <= DATA;
                        tx      <= shreg[0];
                        bit_idx <= '0;
                        cyc     <= div_lat - 16'd1;
                    end else begin
                        cyc <= cyc - 16'd1;
                    end
                end
                DATA: begin
                    if (cyc == 16'd0) begin
                        cyc <= div_lat - 16'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            state <= PARITY;
                            tx    <= parity;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            tx      <= shreg[1];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cyc <= cyc - 16'd1;
                    end
                end
                PARITY: begin
                    if (cyc == 16'd0) begin
                        state <= STOP;
                        tx    <= 1'b1;
                        cyc   <= div_lat - 16'd1;
                    end else begin
                        cyc <= cyc - 16'd1;
                    end
                end
                STOP: begin
                    if (cyc == 16'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cyc <= cyc - 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: stores queue expected frames, a line monitor decodes tx.
// Frame layout follows UART_PARITY_EN when defined for the build.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h8000_0000;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int DRAIN_LIMIT = 5000;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAddress = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] rd_data;
    logic        sel;
    logic        tx;
    logic        busy;

    typedef struct {
        logic [7:0] data;
        int         div;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    bit   mon_busy = 1'b0;
    int   cur_div = 16;
    time  last_edge = 0;

    mmio_uart_tx dut (
        .clk         (clk),
        .Reset       (Reset),
        .MemWrite    (MemWrite),
        .DataAddress (DataAddress),
        .WriteData   (WriteData),
        .rd_data     (rd_data),
        .sel         (sel),
        .tx          (tx),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        MemWrite    = 1'b1;
        DataAddress = addr;
        WriteData   = data;
        @(posedge clk);
        last_edge = $time;
        #1;
        MemWrite = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic s);
        @(negedge clk);
        MemWrite    = 1'b0;
        DataAddress = addr;
        #1;
        data = rd_data;
        s    = sel;
    endtask

    task automatic send(input logic [7:0] b);
        logic [31:0] junk;
        junk = $urandom;
        bus_write(BASE, {junk[31:8], b});
        exp_q.push_back('{data: b, div: cur_div});
    endtask

    task automatic set_div(input logic [15:0] v);
        logic [31:0] junk;
        junk = $urandom;
        bus_write(BASE + 32'd8, {junk[31:16], v});
        cur_div = (v < 16'd2) ? 2 : int'(v);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((busy === 1'b1 || exp_q.size() != 0 || mon_busy) && t < DRAIN_LIMIT) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_done", (t >= DRAIN_LIMIT) ? 32'd1 : 32'd0, 32'd0);
        repeat (3) @(posedge clk);
    endtask

    // Cycles from the edge that accepted the first store to the edge where busy fell.
    task automatic busy_span(input time t0, output int cycles);
        int t;
        t = 0;
        while (busy === 1'b1 && t < DRAIN_LIMIT) begin
            @(posedge clk);
            #1;
            t++;
        end
        cycles = int'(($time - 1 - t0) / 10);
    endtask

    function automatic logic [31:0] frame_bits(input logic [7:0] d);
        logic [31:0] v;
        v = {23'b0, d, 1'b0};
`ifdef UART_PARITY_EN
        v[9]  = ^d;
        v[10] = 1'b1;
`else
        v[9]  = 1'b1;
`endif
        return v;
    endfunction

    // Line monitor: a low level while enabled marks the first cycle of a start bit.
    initial begin : monitor
        exp_t        e;
        logic [31:0] got;
        logic        first;
        int          glitches;
        int          w;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                mon_busy = 1'b1;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_frame: got start bit at %0t expected idle line", $time);
                    w = 0;
                    while (w < 4 * 16 * NB) begin
                        @(negedge clk);
                        w = (tx === 1'b1) ? w + 1 : 0;
                    end
                end else begin
                    e = exp_q.pop_front();
                    got = '0;
                    glitches = 0;
                    first = 1'b0;
                    for (int b = 0; b < NB; b++) begin
                        for (int k = 0; k < e.div; k++) begin
                            if (b != 0 || k != 0) @(negedge clk);
                            if (k == 0) begin
                                first  = tx;
                                got[b] = tx;
                            end else if (tx !== first) begin
                                glitches++;
                            end
                        end
                    end
                    check("frame_bits", got, frame_bits(e.data));
                    check("bit_widths", 32'(glitches), 32'd0);
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : stimulus
        logic [31:0] d;
        logic        s;
        int          lows;
        int          span;
        time         t0;
        logic [15:0] v;
        int          n;

        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        Reset = 1'b0;

        lows = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        check("idle_line", 32'(lows), 32'd0);
        bus_read(BASE + 32'd4, d, s);
        check("status_after_reset", d, 32'h2);
        bus_read(BASE + 32'd8, d, s);
        check("divisor_reset", d, 32'd16);
        mon_en = 1'b1;

        bus_read(BASE, d, s);
        check("txdata_read_data", d, 32'h0);
        check("txdata_sel", 32'(s), 32'd1);
        bus_read(BASE + 32'd8, d, s);
        check("divisor_sel", 32'(s), 32'd1);
        bus_read(BASE + 32'd12, d, s);
        check("above_window_sel", 32'(s), 32'd0);
        check("above_window_data", d, 32'h0);
        bus_read(BASE - 32'd4, d, s);
        check("below_window_sel", 32'(s), 32'd0);

        set_div(16'd0);
        bus_read(BASE + 32'd8, d, s);
        check("divisor_clamp_0", d, 32'd2);
        set_div(16'd1);
        bus_read(BASE + 32'd8, d, s);
        check("divisor_clamp_1", d, 32'd2);

        // Single byte at DIVISOR=4: exact start latency and frame length.
        set_div(16'd4);
        send(8'hA5);
        t0 = last_edge;
        check("tx_idle_at_store", 32'(tx), 32'd1);
        @(posedge clk);
        #1;
        check("tx_start_at_e1", 32'(tx), 32'd0);
        check("busy_at_e1", 32'(busy), 32'd1);
        busy_span(t0, span);
        check("a5_busy_span", 32'(span), 32'(1 + NB * 4));
        wait_drain();

        // Ten stores at DIVISOR=2: first pops immediately, eight fill the FIFO, tenth is dropped.
        set_div(16'd2);
        for (int i = 1; i <= 9; i++) begin
            send(8'(i));
            if (i == 1) t0 = last_edge;
        end
        bus_write(BASE, 32'h0000_000A);
        bus_read(BASE + 32'd4, d, s);
        check("status_overflow", d, 32'hD);
        bus_write(BASE + 32'd4, $urandom);
        bus_read(BASE + 32'd4, d, s);
        check("status_ovf_cleared", d, 32'h5);
        busy_span(t0, span);
        check("burst_busy_span", 32'(span), 32'(1 + 9 * NB * 2));
        wait_drain();
        bus_read(BASE + 32'd4, d, s);
        check("status_drained", d, 32'h2);

        // Divisor change mid-frame applies only from the next frame.
        set_div(16'd4);
        send(8'h5A);
        repeat (10) @(posedge clk);
        set_div(16'd8);
        bus_read(BASE + 32'd8, d, s);
        check("divisor_readback_8", d, 32'd8);
        send(8'hC3);
        wait_drain();

`ifdef UART_PARITY_EN
        set_div(16'd2);
        send(8'h07);
        t0 = last_edge;
        busy_span(t0, span);
        check("parity_busy_span", 32'(span), 32'd23);
        wait_drain();
`endif

        for (int it = 0; it < 6; it++) begin
            v = 16'($urandom_range(0, 6));
            set_div(v);
            bus_read(BASE + 32'd8, d, s);
            check("rand_divisor", d, 32'(cur_div));
            n = $urandom_range(1, 8);
            for (int j = 0; j < n; j++) begin
                send(8'($urandom_range(0, 255)));
            end
            wait_drain();
        end

        // Reset in the middle of 0x3C with two bytes queued: everything is discarded.
        mon_en = 1'b0;
        set_div(16'd4);
        bus_write(BASE, 32'h3C);
        bus_write(BASE, 32'h11);
        bus_write(BASE, 32'h22);
        repeat (8) @(posedge clk);
        #1;
        check("pre_reset_busy", 32'(busy), 32'd1);
        @(negedge clk);
        Reset = 1'b1;
        @(posedge clk);
        #1;
        check("midframe_reset_tx", 32'(tx), 32'd1);
        check("midframe_reset_busy", 32'(busy), 32'd0);
        bus_read(BASE + 32'd4, d, s);
        check("midframe_reset_status", d, 32'h2);
        @(negedge clk);
        Reset = 1'b0;
        cur_div = 16;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        check("no_frames_after_reset", 32'(lows), 32'd0);
        bus_read(BASE + 32'd8, d, s);
        check("divisor_after_reset", d, 32'd16);
        mon_en = 1'b1;

        send(8'h96);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
